sprite_pixel_fetch: RTL and testbench

Per-pixel sprite fetch stage that sits directly downstream of the Nios `sprite_num` PIO. It latches the software-selected sprite number and position once per frame so sprites never tear mid-frame. For each pixel it tests whether the beam is inside the 2^N x 2^N sprite box and addresses the on-chip sprite ROM. It then delivers a registered palette index and a hit flag to the colour mapper.

---
 rtl/sprite_pixel_fetch.sv | 99 +++++++++
 tb/tb_sprite_pixel_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite fetch: frame-latched sprite selection, box test, ROM addressing and a
// registered palette index / hit flag for the colour mapper.
module sprite_pixel_fetch #(
    parameter int unsigned SIZE_LOG2       = 5,
    parameter logic [7:0]  TRANSPARENT_IDX = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               sprite_num,
    input  logic [9:0]               sprite_x,
    input  logic [9:0]               sprite_y,
    input  logic                     frame_start,
    input  logic                     pix_en,
    input  logic [9:0]               draw_x,
    input  logic [9:0]               draw_y,
    output logic [2+2*SIZE_LOG2-1:0] rom_addr,
    input  logic [7:0]               rom_data,
    output logic                     sprite_hit,
    output logic [7:0]               sprite_color,
    output logic [1:0]               active_num
);

    localparam logic [10:0] BoxSize = 11'(1 << SIZE_LOG2);

    typedef enum logic {StIdle, StArmed} arm_state_e;

    arm_state_e                r_state;
    arm_state_e                w_state_next;
    logic [1:0]                r_num_s;
    logic [9:0]                r_x_s;
    logic [9:0]                r_y_s;
    logic                      r_hit_s1;
    logic [2+2*SIZE_LOG2-1:0]  r_rom_addr;
    logic                      r_sprite_hit;
    logic [7:0]                r_sprite_color;

    logic [10:0]               w_dx;
    logic [10:0]               w_dy;
    logic                      w_in_box;
    logic                      w_hit_s2;

    // Arm FSM: leaves IDLE on the first frame_start and stays armed until reset.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (frame_start) w_state_next = StArmed;
            StArmed: w_state_next = StArmed;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_s <= 2'd0;
            r_x_s   <= 10'd0;
            r_y_s   <= 10'd0;
        end else if (frame_start) begin
            r_num_s <= sprite_num;
            r_x_s   <= sprite_x;
            r_y_s   <= sprite_y;
        end
    end

    // Beam left of / above the sprite wraps to a large unsigned offset, so no false hit.
    always_comb begin
        w_dx     = {1'b0, draw_x} - {1'b0, r_x_s};
        w_dy     = {1'b0, draw_y} - {1'b0, r_y_s};
        w_in_box = (w_dx < BoxSize) && (w_dy < BoxSize);
        w_hit_s2 = (r_state == StArmed) && r_hit_s1 && (rom_data != TRANSPARENT_IDX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr     <= '0;
            r_hit_s1       <= 1'b0;
            r_sprite_hit   <= 1'b0;
            r_sprite_color <= 8'h00;
        end else if (pix_en) begin
            r_rom_addr     <= {r_num_s, w_dy[SIZE_LOG2-1:0], w_dx[SIZE_LOG2-1:0]};
            r_hit_s1       <= w_in_box;
            r_sprite_hit   <= w_hit_s2;
            r_sprite_color <= w_hit_s2 ? rom_data : 8'h00;
        end
    end

    assign rom_addr     = r_rom_addr;
    assign sprite_hit   = r_sprite_hit;
    assign sprite_color = r_sprite_color;
    assign active_num   = r_num_s;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: the bench drives rom_data directly and checks
// hand-computed addresses, hit flags and colours.
module tb_sprite_pixel_fetch;

    logic        clk;
    logic        reset_n;
    logic [1:0]  sprite_num;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        frame_start;
    logic        pix_en;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        sprite_hit;
    logic [7:0]  sprite_color;
    logic [1:0]  active_num;

    int n_checks;
    int n_fail;

    sprite_pixel_fetch #(
        .SIZE_LOG2      (5),
        .TRANSPARENT_IDX(8'h00)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sprite_num  (sprite_num),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sprite_hit  (sprite_hit),
        .sprite_color(sprite_color),
        .active_num  (active_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given strobe/frame_start and beam position; returns 1 time unit
    // after the edge with the one-cycle controls dropped.
    task automatic cyc(input logic en, input logic fs, input logic [9:0] x, input logic [9:0] y);
        pix_en      = en;
        frame_start = fs;
        draw_x      = x;
        draw_y      = y;
        @(posedge clk);
        #1;
        pix_en      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic hit, input logic [7:0] col);
        check({tag, "_hit"}, 32'(sprite_hit), 32'(hit));
        check({tag, "_col"}, 32'(sprite_color), 32'(col));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        sprite_num  = 2'd0;
        sprite_x    = 10'd0;
        sprite_y    = 10'd0;
        frame_start = 1'b0;
        pix_en      = 1'b0;
        draw_x      = 10'd0;
        draw_y      = 10'd0;
        rom_data    = 8'h55;

        #3;
        check("rst_addr", 32'(rom_addr), 32'h0);
        check_out("rst", 1'b0, 8'h00);
        check("rst_num", 32'(active_num), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Unarmed: (0,0) is inside the box at shadow (0,0) with ROM 55, yet no hit.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 10'd0, 10'd0);
        check_out("idle", 1'b0, 8'h00);
        check("idle_num", 32'(active_num), 32'd0);

        // Arming edge coincides with a strobe: stage 1 sees old shadows, stage 2 old state.
        sprite_num = 2'd2;
        sprite_x   = 10'd100;
        sprite_y   = 10'd50;
        cyc(1'b1, 1'b1, 10'd0, 10'd0);
        check_out("arm_edge", 1'b0, 8'h00);
        check("arm_addr", 32'(rom_addr), 32'h000);
        check("arm_num", 32'(active_num), 32'd2);

        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        check("tl_addr", 32'(rom_addr), 32'h800);
        cyc(1'b1, 1'b0, 10'd131, 10'd81);
        check_out("tl", 1'b1, 8'h55);
        check("br_addr", 32'(rom_addr), 32'hBFF);
        cyc(1'b1, 1'b0, 10'd132, 10'd50);
        check_out("br", 1'b1, 8'h55);
        cyc(1'b1, 1'b0, 10'd99, 10'd50);
        check_out("right_out", 1'b0, 8'h00);
        check("left_addr", 32'(rom_addr), 32'h81F);
        cyc(1'b1, 1'b0, 10'd100, 10'd49);
        check_out("left_out", 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        check_out("above_out", 1'b0, 8'h00);

        // Transparent texel inside the box.
        rom_data = 8'h00;
        cyc(1'b1, 1'b0, 10'd101, 10'd51);
        check_out("transp", 1'b0, 8'h00);
        rom_data = 8'h55;

        // CPU changes sprite_num mid-frame: not visible until frame_start.
        sprite_num = 2'd1;
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        check("mid_num", 32'(active_num), 32'd2);
        check("mid_addr", 32'(rom_addr), 32'h800);
        cyc(1'b0, 1'b1, 10'd0, 10'd0);
        check("new_num", 32'(active_num), 32'd1);
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        check("new_addr", 32'(rom_addr), 32'h400);

        // frame_start with pix_en: new x only applies from the next strobe.
        sprite_x = 10'd200;
        cyc(1'b1, 1'b1, 10'd100, 10'd50);
        check("fs_old_addr", 32'(rom_addr), 32'h400);
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        check_out("fs_old_hit", 1'b1, 8'h55);
        cyc(1'b1, 1'b0, 10'd0, 10'd0);
        check_out("fs_new_miss", 1'b0, 8'h00);
        sprite_x = 10'd100;
        cyc(1'b0, 1'b1, 10'd0, 10'd0);

        // Strobe gaps with ROM data changing in between.
        cyc(1'b1, 1'b0, 10'd0, 10'd0);
        cyc(1'b1, 1'b0, 10'd0, 10'd0);
        cyc(1'b1, 1'b0, 10'd110, 10'd60);
        check_out("gap0", 1'b0, 8'h00);
        rom_data = 8'h77;
        cyc(1'b0, 1'b0, 10'd0, 10'd0);
        check_out("gap1_hold", 1'b0, 8'h00);
        check("gap1_addr", 32'(rom_addr), 32'h54A);
        rom_data = 8'h66;
        cyc(1'b1, 1'b0, 10'd0, 10'd0);
        check_out("gap2_lat", 1'b1, 8'h66);
        rom_data = 8'h99;
        cyc(1'b0, 1'b0, 10'd0, 10'd0);
        check_out("gap3_hold", 1'b1, 8'h66);
        cyc(1'b1, 1'b0, 10'd0, 10'd0);
        check_out("gap4", 1'b0, 8'h00);
        rom_data = 8'h55;

        // Asynchronous reset mid-line while hitting.
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        cyc(1'b1, 1'b0, 10'd101, 10'd50);
        check_out("pre_rst", 1'b1, 8'h55);
        #1;
        reset_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00);
        check("async_rst_addr", 32'(rom_addr), 32'h0);
        check("async_rst_num", 32'(active_num), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 10'd0, 10'd0);
        check_out("post_rst", 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 10'd0, 10'd0);
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        cyc(1'b1, 1'b0, 10'd100, 10'd50);
        check_out("rearm", 1'b1, 8'h55);
        check("rearm_addr", 32'(rom_addr), 32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
